// File: rtl/click_decoder.sv
// click_decoder: groups debounced press events into click sequences.
// A sequence starts on a press, each further press retriggers the silence
// window and bumps the click count (saturating at MAX_CLICKS). The sequence
// closes when WINDOW_TICKS ticks pass without a press, producing a one-cycle
// out_valid strobe carrying the click count.
//
// Optional build macro: CLICK_DECODER_EARLY_EN
//   defined   -> a sequence also closes as soon as the count reaches MAX_CLICKS
//   undefined -> sequences close only after the silence window
//
// Ports:
//   clk_high   in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   tick       in   one-cycle time-base strobe (window unit)
//   in_pulse   in   one-cycle debounced press event
//   out_valid  out  one-cycle strobe: a sequence has closed
//   out_count  out  clicks in the closed sequence, held between strobes
//   busy       out  high while a sequence is being collected
module click_decoder #(
    parameter int unsigned WINDOW_TICKS = 4,
    parameter int unsigned MAX_CLICKS   = 3
) (
    input  logic       clk_high,
    input  logic       rst,
    input  logic       tick,
    input  logic       in_pulse,
    output logic       out_valid,
    output logic [2:0] out_count,
    output logic       busy
);

    localparam int unsigned CW = 3;
    localparam int unsigned TW = 8;
    localparam logic [CW-1:0] MAX_C   = CW'(MAX_CLICKS);
    localparam logic [TW-1:0] WIN     = TW'(WINDOW_TICKS);
    localparam logic [TW-1:0] TIM_MAX = '1;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   count, count_nx;
    logic [TW-1:0]   timer, timer_nx;
    logic            out_valid_nx;
    logic [CW-1:0]   out_count_nx;
    logic            busy_nx;
    logic            close_c;

    // State and output registers
    always_ff @(posedge clk_high) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            timer     <= '0;
            out_valid <= 1'b0;
            out_count <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            count     <= count_nx;
            timer     <= timer_nx;
            out_valid <= out_valid_nx;
            out_count <= out_count_nx;
            busy      <= busy_nx;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nx     = state;
        count_nx     = count;
        timer_nx     = timer;
        out_valid_nx = 1'b0;
        out_count_nx = out_count;
        close_c      = 1'b0;

        case (state)
            IDLE: begin
                // A lone tick in IDLE is ignored
                if (in_pulse) begin
                    state_nx = COLLECT;
                    count_nx = CW'(1);
                    timer_nx = '0;
                end
            end
            COLLECT: begin
                // A press wins over a coincident tick and retriggers the window
                if (in_pulse) begin
                    count_nx = (count >= MAX_C) ? MAX_C : count + CW'(1);
                    timer_nx = '0;
`ifdef CLICK_DECODER_EARLY_EN
                    if (count_nx == MAX_C) begin
                        close_c = 1'b1;
                    end
`endif
                end else if (tick) begin
                    timer_nx = (timer == TIM_MAX) ? timer : timer + TW'(1);
                    if (timer_nx == WIN) begin
                        close_c = 1'b1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        if (close_c) begin
            state_nx     = IDLE;
            timer_nx     = '0;
            out_valid_nx = 1'b1;
            out_count_nx = count_nx;
        end

        busy_nx = (state_nx == COLLECT);
    end

endmodule

// File: tb/tb_click_decoder.sv
// Self-checking bench for click_decoder (WINDOW_TICKS=4, MAX_CLICKS=3):
// directed scenarios with hand-derived expectations, then randomized traffic
// checked every cycle against a sequence-level reference model.
module tb_click_decoder;

    localparam int unsigned WIN = 4;
    localparam int unsigned MAXC = 3;

    logic       clk_high = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       in_pulse = 1'b0;
    logic       out_valid;
    logic [2:0] out_count;
    logic       busy;

    int checks = 0;
    int failures = 0;

    // Reference model state: is a sequence open, clicks so far, quiet ticks
    bit m_open = 1'b0;
    int m_clicks = 0;
    int m_quiet = 0;
    bit m_valid = 1'b0;
    int m_count = 0;

    click_decoder #(.WINDOW_TICKS(WIN), .MAX_CLICKS(MAXC)) dut (
        .clk_high  (clk_high),
        .rst       (rst),
        .tick      (tick),
        .in_pulse  (in_pulse),
        .out_valid (out_valid),
        .out_count (out_count),
        .busy      (busy)
    );

    always #5 clk_high = ~clk_high;

    // Sequence-level behaviour: what the outputs should be after this cycle
    task automatic model_update(input bit r, input bit p, input bit t);
        m_valid = 1'b0;
        if (r) begin
            m_open = 1'b0; m_clicks = 0; m_quiet = 0; m_count = 0;
        end else if (!m_open) begin
            if (p) begin
                m_open = 1'b1; m_clicks = 1; m_quiet = 0;
            end
        end else if (p) begin
            m_clicks = (m_clicks + 1 > MAXC) ? MAXC : m_clicks + 1;
            m_quiet = 0;
`ifdef CLICK_DECODER_EARLY_EN
            if (m_clicks == MAXC) begin
                m_valid = 1'b1; m_count = m_clicks; m_open = 1'b0;
            end
`endif
        end else if (t) begin
            m_quiet++;
            if (m_quiet == WIN) begin
                m_valid = 1'b1; m_count = m_clicks; m_open = 1'b0;
            end
        end
    endtask

    // Apply one cycle of inputs, then sample #1 after the edge
    task automatic step(input bit r, input bit p, input bit t);
        rst = r; in_pulse = p; tick = t;
        @(posedge clk_high);
        #1;
        model_update(r, p, t);
        rst = 1'b0; in_pulse = 1'b0; tick = 1'b0;
    endtask

    task automatic test_reset();
        step(1, 1, 1);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_count !== 3'd0) begin
            failures++;
            $display("FAIL reset: valid=%b busy=%b count=%0d expected 0/0/0", out_valid, busy, out_count);
        end
    endtask

    task automatic test_single();
        step(0, 1, 0);
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_start: busy=%b valid=%b expected 1/0", busy, out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1);
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL single_wait: tick %0d valid=%b busy=%b expected 0/1", i, out_valid, busy);
            end
        end
        step(0, 0, 1);
        checks++;
        if (out_valid !== 1'b1 || out_count !== 3'd1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_close: valid=%b count=%0d busy=%b expected 1/1/0", out_valid, out_count, busy);
        end
        step(0, 0, 0);
        checks++;
        if (out_valid !== 1'b0 || out_count !== 3'd1) begin
            failures++;
            $display("FAIL single_hold: valid=%b count=%0d expected 0/1", out_valid, out_count);
        end
    endtask

    task automatic test_double();
        step(0, 1, 0);
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL double_early: valid=%b busy=%b expected 0/1", out_valid, busy);
        end
        step(0, 0, 1);
        checks++;
        if (out_valid !== 1'b1 || out_count !== 3'd2) begin
            failures++;
            $display("FAIL double_close: valid=%b count=%0d expected 1/2", out_valid, out_count);
        end
    endtask

    task automatic test_saturate();
        int nv = 0;
        int first_at = -1;
        int cyc = 0;
        logic [2:0] c0 = '0;
        logic [2:0] c1 = '0;
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0);
            if (out_valid === 1'b1) begin
                if (nv == 0) begin c0 = out_count; first_at = cyc; end else c1 = out_count;
                nv++;
            end
            cyc++;
            if (i < 4) begin
                step(0, 0, 1);
                if (out_valid === 1'b1) begin
                    if (nv == 0) begin c0 = out_count; first_at = cyc; end else c1 = out_count;
                    nv++;
                end
                cyc++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1);
            if (out_valid === 1'b1) begin
                if (nv == 0) begin c0 = out_count; first_at = cyc; end else c1 = out_count;
                nv++;
            end
            cyc++;
        end
`ifdef CLICK_DECODER_EARLY_EN
        checks++;
        if (nv != 2 || c0 !== 3'd3 || c1 !== 3'd2 || first_at != 4) begin
            failures++;
            $display("FAIL saturate: strobes=%0d counts=%0d,%0d first=%0d expected 2 strobes 3,2 first=4", nv, c0, c1, first_at);
        end
`else
        checks++;
        if (nv != 1 || c0 !== 3'd3 || first_at != 12) begin
            failures++;
            $display("FAIL saturate: strobes=%0d count=%0d first=%0d expected 1 strobe 3 first=12", nv, c0, first_at);
        end
`endif
    endtask

    task automatic test_coincide();
        step(0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        step(0, 1, 1);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL coincide: valid=%b busy=%b expected 0/1", out_valid, busy);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL coincide_wait: valid=%b expected 0", out_valid);
        end
        step(0, 0, 1);
        checks++;
        if (out_valid !== 1'b1 || out_count !== 3'd2) begin
            failures++;
            $display("FAIL coincide_close: valid=%b count=%0d expected 1/2", out_valid, out_count);
        end
    endtask

    task automatic test_abort();
        int nv = 0;
        step(0, 1, 0);
        step(0, 0, 1);
        step(0, 0, 1);
        step(1, 0, 0);
        checks++;
        if (busy !== 1'b0 || out_count !== 3'd0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort: busy=%b count=%0d valid=%b expected 0/0/0", busy, out_count, out_valid);
        end
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1);
            if (out_valid === 1'b1) nv++;
        end
        checks++;
        if (nv != 0) begin
            failures++;
            $display("FAIL abort_silent: strobes=%0d expected 0", nv);
        end
    endtask

    task automatic test_idle_ticks();
        int bad = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 1);
            if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL idle_ticks: cycles with activity=%0d expected 0", bad);
        end
    endtask

    task automatic test_random();
        step(1, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            bit r = ($urandom_range(0, 99) == 0);
            bit p = ($urandom_range(0, 4) == 0);
            bit t = ($urandom_range(0, 1) == 0);
            step(r, p, t);
            checks++;
            if (out_valid !== m_valid || busy !== m_open || out_count !== 3'(m_count)) begin
                failures++;
                $display("FAIL random cyc %0d: valid=%b busy=%b count=%0d expected %b/%b/%0d",
                         i, out_valid, busy, out_count, m_valid, m_open, m_count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_double();
        test_saturate();
        test_coincide();
        test_abort();
        test_idle_ticks();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/click_decoder.md
CLICK_DECODER -- requirements
Module: click_decoder

Interface
REQ-001 Parameter WINDOW_TICKS, default 4: ticks of silence that close a click sequence; legal range 1..255.
REQ-002 Parameter MAX_CLICKS, default 3: saturation value of the click count; legal range 2..7.
REQ-003 clk_high  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 tick  input  1  one-cycle time-base strobe, synchronous to clk_high; defines the window unit.
REQ-006 in_pulse  input  1  one-cycle debounced press event, synchronous to clk_high.
REQ-007 out_valid  output  1  one-cycle strobe: a click sequence has closed.
REQ-008 out_count  output  3  clicks in the closed sequence, range 1..MAX_CLICKS; valid while out_valid=1.
REQ-009 busy  output  1  high while a sequence is being collected.

Function
REQ-010 The FSM SHALL have states IDLE and COLLECT; busy SHALL equal (state==COLLECT), registered.
REQ-011 IDLE + in_pulse SHALL load count=1, clear timer, and go to COLLECT; IDLE + tick alone SHALL do nothing.
REQ-012 COLLECT + in_pulse SHALL set count=min(count+1, MAX_CLICKS) and clear timer (window retriggers).
REQ-013 After saturation, further in_pulse SHALL leave count at MAX_CLICKS and still clear timer.
REQ-014 COLLECT + tick without in_pulse SHALL increment timer (8-bit, never wraps).
REQ-015 The sequence closes on the tick that makes timer reach WINDOW_TICKS.
REQ-016 On close, the next cycle SHALL have out_valid=1 for exactly one cycle with out_count=count, and state SHALL return to IDLE.
REQ-017 in_pulse and tick in the same COLLECT cycle: in_pulse SHALL win; count increments, timer clears, no close.
REQ-018 in_pulse in the cycle where out_valid is high SHALL start a new sequence per REQ-011.
REQ-019 out_count SHALL hold its last value between out_valid strobes.
REQ-020 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-021 rst=1 SHALL force state=IDLE, count=0, timer=0, out_valid=0, out_count=0, busy=0 at the next clk_high edge.
REQ-022 rst SHALL override in_pulse and tick in the same cycle.
REQ-023 A sequence aborted by rst SHALL produce no out_valid.

Configuration
REQ-024 Macro CLICK_DECODER_EARLY_EN defined: when count reaches MAX_CLICKS, the sequence SHALL close without waiting for the window, and out_valid SHALL be asserted the cycle after the saturating in_pulse.
REQ-025 CLICK_DECODER_EARLY_EN undefined: a saturated sequence SHALL close only per REQ-015.

Verification (WINDOW_TICKS=4, MAX_CLICKS=3)
REQ-026 One in_pulse, then 4 ticks -> out_valid high the cycle after the 4th tick, out_count=1, busy=0 in that cycle.
REQ-027 in_pulse, 2 ticks, in_pulse, 4 ticks -> single out_valid, out_count=2; 3 ticks after the 2nd pulse -> no out_valid yet.
REQ-028 5 in_pulse, 1 tick apart -> without macro, one out_valid with out_count=3 after 4 quiet ticks; with CLICK_DECODER_EARLY_EN, out_valid with out_count=3 the cycle after the 3rd pulse, then a second out_valid with out_count=2.
REQ-029 After 1 pulse and 3 ticks, in_pulse coincides with the 4th tick -> no out_valid; 4 more ticks -> out_count=2.
REQ-030 rst after 1 pulse and 2 ticks -> busy=0, out_count=0 next cycle; 10 further ticks -> no out_valid.
REQ-031 20 ticks with no in_pulse from IDLE -> out_valid and busy stay 0.
